// File: rtl/rob_multi.sv
// rob_multi: multi-slot reorder buffer with in-order retire, exception self-flush and explicit flush
module rob_multi #(
    parameter int DEPTH    = 16,
    parameter int ALLOC_W  = 2,
    parameter int RETIRE_W = 2,
    parameter int CMPL_W   = 2,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [ALLOC_W-1:0]      alloc_valid,
    input  logic [ALLOC_W*5-1:0]    alloc_dst,
    input  logic [ALLOC_W*32-1:0]   alloc_pc,
    output logic                    alloc_ready,
    output logic [ALLOC_W*TAG_W-1:0] alloc_tag,
    input  logic [CMPL_W-1:0]       cmpl_valid,
    input  logic [CMPL_W*TAG_W-1:0] cmpl_tag,
    input  logic [CMPL_W*32-1:0]    cmpl_data,
    input  logic [CMPL_W-1:0]       cmpl_exc,
    output logic [RETIRE_W-1:0]     retire_valid,
    output logic [RETIRE_W*5-1:0]   retire_dst,
    output logic [RETIRE_W*32-1:0]  retire_data,
    output logic [RETIRE_W*32-1:0]  retire_pc,
    output logic                    exc_valid,
    output logic [31:0]             exc_pc,
    output logic [TAG_W:0]          count
);
    logic [TAG_W:0]       r_head, r_tail;
    logic [DEPTH-1:0]     r_valid, r_done, r_exc;
    logic [4:0]           r_dst  [DEPTH];
    logic [31:0]          r_pc   [DEPTH];
    logic [31:0]          r_data [DEPTH];
    logic [TAG_W:0]       w_count, w_alloc_n, w_ret_n;
    logic [TAG_W-1:0]     w_alloc_idx [ALLOC_W];
    logic [TAG_W-1:0]     w_ret_idx   [RETIRE_W];
    logic                 w_live, w_do_alloc, w_run, w_exc_hit;
    logic [31:0]          w_exc_pc;

    assign w_count     = r_tail - r_head;
    assign count       = w_count;
    assign alloc_ready = (DEPTH - int'(w_count)) >= ALLOC_W;
    assign w_live      = resetn && !flush;
    assign w_do_alloc  = alloc_ready && !flush;
    assign exc_valid   = w_exc_hit && w_live;
    assign exc_pc      = exc_valid ? w_exc_pc : '0;

    // valid slots take consecutive tags from the tail, skipping idle slots
    always_comb begin
        w_alloc_n = '0;
        alloc_tag = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            w_alloc_idx[i] = r_tail[TAG_W-1:0] + w_alloc_n[TAG_W-1:0];
            alloc_tag[i*TAG_W +: TAG_W] = resetn ? w_alloc_idx[i] : TAG_W'(i);
            w_alloc_n = w_alloc_n + (TAG_W+1)'(alloc_valid[i]);
        end
    end

    always_comb begin
        w_run        = 1'b1;
        w_exc_hit    = 1'b0;
        w_exc_pc     = '0;
        w_ret_n      = '0;
        retire_valid = '0;
        retire_dst   = '0;
        retire_data  = '0;
        retire_pc    = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            w_ret_idx[i] = r_head[TAG_W-1:0] + TAG_W'(i);
            retire_dst[i*5 +: 5]   = r_dst[w_ret_idx[i]];
            retire_data[i*32 +: 32] = r_data[w_ret_idx[i]];
            retire_pc[i*32 +: 32]  = r_pc[w_ret_idx[i]];
            if (w_run && r_valid[w_ret_idx[i]] && r_done[w_ret_idx[i]] && r_exc[w_ret_idx[i]]) begin
                w_exc_hit = 1'b1;
                w_exc_pc  = r_pc[w_ret_idx[i]];
            end
            w_run = w_run && r_valid[w_ret_idx[i]] && r_done[w_ret_idx[i]] && !r_exc[w_ret_idx[i]];
            retire_valid[i] = w_run && w_live;
            w_ret_n = w_ret_n + (TAG_W+1)'(retire_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_exc   <= '0;
        end else if (flush || exc_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_exc   <= '0;
        end else begin
            // ascending port order lets the higher port win on a shared tag
            for (int p = 0; p < CMPL_W; p++) begin
                if (cmpl_valid[p] && r_valid[cmpl_tag[p*TAG_W +: TAG_W]]) begin
                    r_done[cmpl_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    r_exc[cmpl_tag[p*TAG_W +: TAG_W]]  <= r_exc[cmpl_tag[p*TAG_W +: TAG_W]] | cmpl_exc[p];
                end
            end
            for (int i = 0; i < RETIRE_W; i++) begin
                if (retire_valid[i])
                    r_valid[w_ret_idx[i]] <= 1'b0;
            end
            for (int i = 0; i < ALLOC_W; i++) begin
                if (w_do_alloc && alloc_valid[i]) begin
                    r_valid[w_alloc_idx[i]] <= 1'b1;
                    r_done[w_alloc_idx[i]]  <= 1'b0;
                    r_exc[w_alloc_idx[i]]   <= 1'b0;
                end
            end
            r_head <= r_head + w_ret_n;
            r_tail <= r_tail + (w_do_alloc ? w_alloc_n : '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < CMPL_W; p++) begin
            if (cmpl_valid[p] && r_valid[cmpl_tag[p*TAG_W +: TAG_W]])
                r_data[cmpl_tag[p*TAG_W +: TAG_W]] <= cmpl_data[p*32 +: 32];
        end
        for (int i = 0; i < ALLOC_W; i++) begin
            if (w_do_alloc && alloc_valid[i]) begin
                r_dst[w_alloc_idx[i]] <= alloc_dst[i*5 +: 5];
                r_pc[w_alloc_idx[i]]  <= alloc_pc[i*32 +: 32];
            end
        end
    end
endmodule
